sprite_palette_bank: RTL and testbench
======================================

Name: sprite_palette_bank

Overview:
- Runtime-loadable, multi-bank sprite palette RAM that replaces the per-frame hard-wired palette lookups.
- Each bank holds one animation frame's palette.
- Pixel lookups are pipelined and flag the background key colour as transparent.
- An optional frame-tick-driven animation counter rotates banks automatically.
- Sits between the sprite ROM index output and the VGA colour mapper.

Parameters:
- NUM_BANKS, 8, number of palettes; power of two; BANK_W = log2(NUM_BANKS).
- INDEX_W, 4, colour index width; 2^INDEX_W entries per bank.
- CHAN_W, 4, bits per colour channel.
- KEY_COLOR, 12'h6AF, {R,G,B} value treated as transparent and used as the init fill; width 3*CHAN_W.
- ANIM_DIV, 4, frame_tick pulses per animation step; must be >= 1.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous active-high reset.
- wr_en, in, 1, write request.
- wr_bank, in, BANK_W, write bank.
- wr_index, in, INDEX_W, write entry.
- wr_rgb, in, 3*CHAN_W, write data {R,G,B}.
- wr_ready, out, 1, high when writes and lookups are accepted.
- rd_valid, in, 1, lookup request.
- rd_bank, in, BANK_W, base bank for lookup.
- rd_index, in, INDEX_W, colour index.
- frame_tick, in, 1, one-cycle pulse per video frame (vsync-derived).
- anim_len, in, BANK_W+1, animation length in banks; 0 or 1 disables rotation.
- anim_frame, out, BANK_W, current animation offset.
- out_valid, out, 1, lookup result valid.
- red, out, CHAN_W, red channel.
- green, out, CHAN_W, green channel.
- blue, out, CHAN_W, blue channel.
- transparent, out, 1, result equals KEY_COLOR.

Behaviour:
- Reset values: wr_ready=0, out_valid=0, red/green/blue=0, transparent=0, anim_frame=0, internal divider=0, pipeline valids=0. FSM enters INIT.
- FSM states: INIT, READY.
- INIT:
  - A counter sweeps all NUM_BANKS*2^INDEX_W entries, one per cycle, writing KEY_COLOR.
  - Sweep starts on the first cycle after Reset deasserts.
  - On the last entry the FSM moves to READY; wr_ready=1 starting exactly NUM_BANKS*2^INDEX_W cycles after Reset deasserts (128 with defaults).
  - wr_en, rd_valid and frame_tick are ignored in INIT.
- READY:
  - wr_en writes wr_rgb to entry {wr_bank, wr_index} at the clock edge.
  - No backpressure; wr_ready stays 1.
- Lookup pipeline, latency 2:
  - Cycle N: rd_valid sampled; effective bank = (rd_bank + anim_frame) mod NUM_BANKS, with natural wrap in BANK_W bits, using anim_frame as it is in cycle N.
  - Cycle N+1: synchronous RAM read registered.
  - Cycle N+2: red/green/blue/transparent registered; out_valid=1 for exactly one cycle per request.
  - Full throughput: one lookup per cycle, back-to-back.
  - When out_valid=0, colour outputs hold their last values and transparent holds.
- Read/write collision: a read issued in the same cycle as a write to the same entry returns the OLD data. A read issued one cycle after the write returns the new data.
- transparent = (registered RGB == KEY_COLOR), computed in the output stage.
- Animation, READY only:
  - On each frame_tick the divider increments.
  - When divider == ANIM_DIV-1 and frame_tick is high: divider <= 0, and anim_frame <= (anim_frame+1 >= anim_len) ? 0 : anim_frame+1.
  - If anim_len <= 1, anim_frame is forced to 0 on the next step and held there.
  - If anim_len is reduced below the current anim_frame+1, the next step wraps to 0.
- Reset mid-operation (any state, including pipeline in flight):
  - Next cycle all outputs return to their reset values and in-flight lookups are dropped (no out_valid).
  - Animation counters clear and the full INIT sweep reruns.
- Simultaneous wr_en, rd_valid and frame_tick in one cycle are all legal and independent.

Test Plan:
- Reset release, defaults -> wr_ready rises exactly 128 cycles later. Then read bank 5 index 9 -> 2 cycles later RGB=6,A,F, transparent=1, out_valid high for 1 cycle.
- Write bank 2 index 1 = 12'h940, read {2,1} on the following cycle -> RGB=9,4,0, transparent=0. Back-to-back reads of {2,1},{2,0} -> out_valid high 2 consecutive cycles with 940 then 6AF.
- Same-cycle write {3,4}=12'h520 and read {3,4} -> returns 6AF. Re-read next cycle -> 520.
- anim_len=3, ANIM_DIV=4, 12 frame_ticks -> anim_frame sequence 0,1,2,0 changing on ticks 4, 8, 12. With anim_frame=2 and rd_bank=7, the lookup reads bank 1 (wrap).
- wr_en asserted during INIT to {0,0}=12'hFFF -> ignored; after READY, {0,0} still reads 6AF.
- Reset asserted while 2 lookups are in flight and anim_frame=2 -> no out_valid, anim_frame=0, wr_ready=0, previously written entries read back 6AF after re-init.

Source files
------------

// File: rtl/sprite_palette_bank.sv
// Multi-bank sprite palette RAM with a two-stage lookup pipeline, key-colour
// transparency flag and a frame-tick driven bank rotation counter.
//
// state | meaning
// INIT  | sweeping every palette entry to KEY_COLOR, writes/lookups/ticks ignored
// READY | writes, lookups and animation active
module sprite_palette_bank #(
   parameter int                  NUM_BANKS = 8,
   parameter int                  INDEX_W   = 4,
   parameter int                  CHAN_W    = 4,
   parameter logic [3*CHAN_W-1:0] KEY_COLOR = 12'h6AF,
   parameter int                  ANIM_DIV  = 4,
   localparam int                 BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [BANK_W-1:0]   wr_bank,
   input  logic [INDEX_W-1:0]  wr_index,
   input  logic [3*CHAN_W-1:0] wr_rgb,
   output logic                wr_ready,
   input  logic                rd_valid,
   input  logic [BANK_W-1:0]   rd_bank,
   input  logic [INDEX_W-1:0]  rd_index,
   input  logic                frame_tick,
   input  logic [BANK_W:0]     anim_len,
   output logic [BANK_W-1:0]   anim_frame,
   output logic                out_valid,
   output logic [CHAN_W-1:0]   red,
   output logic [CHAN_W-1:0]   green,
   output logic [CHAN_W-1:0]   blue,
   output logic                transparent
);

   localparam int ENTRY_W = BANK_W + INDEX_W;
   localparam int DEPTH   = NUM_BANKS << INDEX_W;
   localparam int RGB_W   = 3 * CHAN_W;
   localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t             state;
   logic [ENTRY_W-1:0] init_addr;
   logic [DIV_W-1:0]   div_cnt;
   logic               rd_v;
   logic [RGB_W-1:0]   rd_data;
   logic [RGB_W-1:0]   mem [DEPTH];

   logic               mem_we;
   logic [ENTRY_W-1:0] mem_waddr;
   logic [RGB_W-1:0]   mem_wdata;
   logic [BANK_W-1:0]  eff_bank;
   logic [ENTRY_W-1:0] rd_addr;
   logic [BANK_W:0]    next_frame;

   // The init sweep owns the write port until READY; user writes are dropped.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = init_addr;
      mem_wdata = KEY_COLOR;
      if (!reset) begin
         if (state == ST_INIT) begin
            mem_we = 1'b1;
         end else if (wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_bank, wr_index};
            mem_wdata = wr_rgb;
         end
      end
   end

   assign eff_bank   = rd_bank + anim_frame;
   assign rd_addr    = {eff_bank, rd_index};
   assign next_frame = {1'b0, anim_frame} + (BANK_W+1)'(1);

   // Read samples the pre-write contents, so a same-cycle collision returns old data.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_INIT;
         init_addr   <= '0;
         wr_ready    <= 1'b0;
         div_cnt     <= '0;
         anim_frame  <= '0;
         rd_v        <= 1'b0;
         out_valid   <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         transparent <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_addr <= init_addr + ENTRY_W'(1);
               if (init_addr == ENTRY_W'(DEPTH - 1)) begin
                  state    <= ST_READY;
                  wr_ready <= 1'b1;
               end
            end
            ST_READY: begin
               if (frame_tick) begin
                  if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                     div_cnt <= '0;
                     if (next_frame >= anim_len) anim_frame <= '0;
                     else                        anim_frame <= next_frame[BANK_W-1:0];
                  end else begin
                     div_cnt <= div_cnt + DIV_W'(1);
                  end
               end
            end
            default: state <= ST_INIT;
         endcase

         rd_v      <= rd_valid && (state == ST_READY);
         out_valid <= rd_v;
         if (rd_v) begin
            red         <= rd_data[RGB_W-1 -: CHAN_W];
            green       <= rd_data[2*CHAN_W-1 -: CHAN_W];
            blue        <= rd_data[CHAN_W-1:0];
            transparent <= (rd_data == KEY_COLOR);
         end
      end
   end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank: per-cycle comparison against a
// behavioural palette model plus hand-computed literal expectations.
module tb_sprite_palette_bank;
   localparam int KEY = 12'h6AF;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [2:0]  wr_bank;
   logic [3:0]  wr_index;
   logic [11:0] wr_rgb;
   logic        wr_ready;
   logic        rd_valid;
   logic [2:0]  rd_bank;
   logic [3:0]  rd_index;
   logic        frame_tick;
   logic [3:0]  anim_len;
   logic [2:0]  anim_frame;
   logic        out_valid;
   logic [3:0]  red, green, blue;
   logic        transparent;

   always #5 clk = ~clk;

   sprite_palette_bank dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_bank(wr_bank),
      .wr_index(wr_index), .wr_rgb(wr_rgb), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_index(rd_index),
      .frame_tick(frame_tick), .anim_len(anim_len), .anim_frame(anim_frame),
      .out_valid(out_valid), .red(red), .green(green), .blue(blue),
      .transparent(transparent)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: palette array, tick count, animation offset and a
   // queue of pending lookup results keyed by the edge they appear after.
   int m_mem[128];
   int m_anim, m_ticks, m_since, m_edge;
   bit m_on = 1'b0;
   int m_v, m_rgb, m_tr;
   int q_due[$];
   int q_rgb[$];

   always @(negedge clk) begin
      if (m_on) begin
         chk("model_wr_ready", int'(wr_ready), int'(m_since >= 128));
         chk("model_out_valid", int'(out_valid), m_v);
         chk("model_rgb", int'({red, green, blue}), m_rgb);
         chk("model_transparent", int'(transparent), m_tr);
         chk("model_anim_frame", int'(anim_frame), m_anim);
      end
      if (reset) begin
         m_on = 1'b1;
         foreach (m_mem[i]) m_mem[i] = KEY;
         m_anim = 0; m_ticks = 0; m_since = 0;
         m_v = 0; m_rgb = 0; m_tr = 0;
         q_due.delete(); q_rgb.delete();
      end else if (m_on) begin
         m_v = 0;
         if (q_due.size() > 0 && q_due[0] == m_edge) begin
            m_v   = 1;
            m_rgb = q_rgb.pop_front();
            void'(q_due.pop_front());
            m_tr  = (m_rgb == KEY) ? 1 : 0;
         end
         if (m_since >= 128) begin
            if (rd_valid) begin
               q_due.push_back(m_edge + 1);
               q_rgb.push_back(m_mem[((int'(rd_bank) + m_anim) % 8) * 16 + int'(rd_index)]);
            end
            if (wr_en) m_mem[int'(wr_bank) * 16 + int'(wr_index)] = int'(wr_rgb);
            if (frame_tick) begin
               m_ticks++;
               if (m_ticks % 4 == 0) m_anim = (m_anim + 1 >= int'(anim_len)) ? 0 : m_anim + 1;
            end
         end
         m_since++;
      end
      m_edge++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input int b, input int i, input int exp, input string nm);
      rd_valid = 1'b1; rd_bank = 3'(b); rd_index = 4'(i);
      step();
      rd_valid = 1'b0;
      step();
      chk({nm, "_valid"}, int'(out_valid), 1);
      chk({nm, "_rgb"}, int'({red, green, blue}), exp);
      chk({nm, "_transparent"}, int'(transparent), (exp == KEY) ? 1 : 0);
      step();
      chk({nm, "_valid_drop"}, int'(out_valid), 0);
   endtask

   task automatic wr(input int b, input int i, input int rgb);
      wr_en = 1'b1; wr_bank = 3'(b); wr_index = 4'(i); wr_rgb = 12'(rgb);
      step();
      wr_en = 1'b0;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   int n;

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0;
      rd_valid = 1'b0; rd_bank = '0; rd_index = '0; frame_tick = 1'b0; anim_len = 4'd3;
      repeat (3) step();
      chk("reset_wr_ready", int'(wr_ready), 0);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_anim_frame", int'(anim_frame), 0);

      // Release reset while hammering writes, lookups and ticks that INIT must ignore.
      reset = 1'b0;
      wr_en = 1'b1; wr_bank = 3'd0; wr_index = 4'd0; wr_rgb = 12'hFFF;
      rd_valid = 1'b1; frame_tick = 1'b1;
      n = 0;
      while (!wr_ready && n < 400) begin
         step();
         n++;
         if (n == 3) begin wr_en = 1'b0; rd_valid = 1'b0; frame_tick = 1'b0; end
      end
      chk("ready_latency", n, 128);

      rd_check(5, 9, 12'h6AF, "init_key_b5i9");
      rd_check(0, 0, 12'h6AF, "init_write_ignored");

      // Write then read next cycle, back-to-back with a second lookup.
      wr_en = 1'b1; wr_bank = 3'd2; wr_index = 4'd1; wr_rgb = 12'h940;
      step();
      wr_en = 1'b0; rd_valid = 1'b1; rd_bank = 3'd2; rd_index = 4'd1;
      step();
      rd_index = 4'd0;
      step();
      rd_valid = 1'b0;
      chk("b2b_first_valid", int'(out_valid), 1);
      chk("b2b_first_rgb", int'({red, green, blue}), 12'h940);
      chk("b2b_first_transparent", int'(transparent), 0);
      step();
      chk("b2b_second_valid", int'(out_valid), 1);
      chk("b2b_second_rgb", int'({red, green, blue}), 12'h6AF);
      step();
      chk("b2b_end_valid", int'(out_valid), 0);
      chk("hold_rgb", int'({red, green, blue}), 12'h6AF);

      // Same-cycle write/read collision returns old data; next cycle returns new.
      wr_en = 1'b1; wr_bank = 3'd3; wr_index = 4'd4; wr_rgb = 12'h520;
      rd_valid = 1'b1; rd_bank = 3'd3; rd_index = 4'd4;
      step();
      wr_en = 1'b0;
      step();
      rd_valid = 1'b0;
      chk("collision_old_rgb", int'({red, green, blue}), 12'h6AF);
      step();
      chk("collision_new_rgb", int'({red, green, blue}), 12'h520);
      chk("collision_new_valid", int'(out_valid), 1);

      wr(1, 5, 12'h123);
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (t == 3)  chk("anim_tick3", int'(anim_frame), 0);
         if (t == 4)  chk("anim_tick4", int'(anim_frame), 1);
         if (t == 7)  chk("anim_tick7", int'(anim_frame), 1);
         if (t == 8)  chk("anim_tick8", int'(anim_frame), 2);
         if (t == 12) chk("anim_tick12", int'(anim_frame), 0);
      end
      repeat (8) tick();
      chk("anim_after20", int'(anim_frame), 2);
      rd_check(7, 5, 12'h123, "anim_wrap_bank1");

      // Reset with two lookups in flight.
      rd_valid = 1'b1; rd_bank = 3'd2; rd_index = 4'd1;
      step();
      rd_bank = 3'd0; rd_index = 4'd0; reset = 1'b1;
      step();
      reset = 1'b0; rd_valid = 1'b0;
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_anim_frame", int'(anim_frame), 0);
      chk("midreset_wr_ready", int'(wr_ready), 0);
      n = 0;
      while (!wr_ready && n < 400) begin
         step();
         n++;
         if (n == 1) chk("midreset_out_valid2", int'(out_valid), 0);
      end
      chk("reinit_latency", n, 128);
      rd_check(2, 1, 12'h6AF, "reinit_b2i1");
      rd_check(1, 5, 12'h6AF, "reinit_b1i5");

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
